// File: rtl/fault_campaign_engine.sv
// fault_campaign_engine
//   Sequential fault-injection campaign controller for a WIDTH-bit adder under
//   test. For every fault code 0..NUM_FAULTS-1 it drives fault_sel, sweeps the
//   full {a,b,cin} input space, and compares the DUT response with an internal
//   golden adder. After each fault it emits one result record.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 begin a campaign (sampled only while idle)
//   busy, done            campaign in progress / one-cycle completion pulse
//   vec_a, vec_b, vec_cin registered stimulus to the DUT
//   fault_sel             registered active fault code to the DUT
//   dut_sum, dut_cout     combinational DUT response to the current stimulus
//   res_valid, res_ready  result record handshake
//   res_fault             fault code of the record
//   res_detected          any mismatch seen for this fault
//   res_sum_det           some vector mismatched on the sum bits
//   res_carry_det         some vector mismatched on the carry-out
//   res_count             number of mismatching vectors
//   res_first_vec         index of the first mismatching vector (0 if none)
//   total_detected        number of detected faults in this campaign
module fault_campaign_engine #(
  parameter int WIDTH      = 4,
  parameter int NUM_FAULTS = 8,
  parameter int FSW        = 3,
  parameter int EARLY_EXIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     vec_a,
  output logic [WIDTH-1:0]     vec_b,
  output logic                 vec_cin,
  output logic [FSW-1:0]       fault_sel,
  input  logic [WIDTH-1:0]     dut_sum,
  input  logic                 dut_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [FSW-1:0]       res_fault,
  output logic                 res_detected,
  output logic                 res_sum_det,
  output logic                 res_carry_det,
  output logic [2*WIDTH+1:0]   res_count,
  output logic [2*WIDTH:0]     res_first_vec,
  output logic [FSW:0]         total_detected
);

  localparam int VW = 2*WIDTH + 1;
  localparam int CW = 2*WIDTH + 2;
  localparam logic [VW-1:0]  VLAST = '1;
  localparam logic [FSW-1:0] FLAST = FSW'(NUM_FAULTS - 1);
  localparam bit             EE    = (EARLY_EXIT != 0);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_REPORT, S_DONE} state_t;

  state_t          state;
  logic [VW-1:0]   vidx;
  logic [WIDTH:0]  gold;
  logic            sum_mis;
  logic            carry_mis;
  logic            mismatch;

  // The vector index register is the stimulus register; the DUT ports are
  // just its fields, so no separate copy can drift out of step.
  assign vec_cin = vidx[0];
  assign vec_b   = vidx[WIDTH:1];
  assign vec_a   = vidx[2*WIDTH:WIDTH+1];

  assign gold      = {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
  assign sum_mis   = (dut_sum != gold[WIDTH-1:0]);
  assign carry_mis = (dut_cout != gold[WIDTH]);
  assign mismatch  = sum_mis | carry_mis;

  assign res_fault    = fault_sel;
  assign res_detected = (res_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      res_valid      <= 1'b0;
      vidx           <= '0;
      fault_sel      <= '0;
      res_count      <= '0;
      res_sum_det    <= 1'b0;
      res_carry_det  <= 1'b0;
      res_first_vec  <= '0;
      total_detected <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state          <= S_APPLY;
            busy           <= 1'b1;
            vidx           <= '0;
            fault_sel      <= '0;
            res_count      <= '0;
            res_sum_det    <= 1'b0;
            res_carry_det  <= 1'b0;
            res_first_vec  <= '0;
            total_detected <= '0;
          end
        end

        S_APPLY: begin
          if (mismatch) begin
            res_count     <= res_count + CW'(1);
            res_sum_det   <= res_sum_det | sum_mis;
            res_carry_det <= res_carry_det | carry_mis;
            if (res_count == '0) res_first_vec <= vidx;
          end
          // The index stays on the last applied vector so the record is
          // presented alongside the stimulus that ended the sweep.
          if (vidx == VLAST || (EE && mismatch)) begin
            state     <= S_REPORT;
            res_valid <= 1'b1;
          end else begin
            vidx <= vidx + VW'(1);
          end
        end

        S_REPORT: begin
          if (res_ready) begin
            res_valid      <= 1'b0;
            total_detected <= total_detected + {{FSW{1'b0}}, res_detected};
            if (fault_sel == FLAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state         <= S_APPLY;
              fault_sel     <= fault_sel + FSW'(1);
              vidx          <= '0;
              res_count     <= '0;
              res_sum_det   <= 1'b0;
              res_carry_det <= 1'b0;
              res_first_vec <= '0;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
